race_position_tracker: RTL and testbench

Downstream consumer of the menu stage's is_in_menu output. Takes the four players' raw push-buttons and, once the menu/countdown phase ends, converts debounced presses into per-player track positions. Detects the winner(s) at the finish line and freezes the race until the design re-enters the menu. Positions and winner feed the LED strip renderer.

---
 rtl/race_position_tracker_if.sv | 28 ++
 rtl/race_position_tracker.sv | 156 +++++++++++++++
 tb/tb_race_position_tracker.sv | 390 +++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/race_position_tracker_if.sv
// Bundles the menu flag, four raw player buttons and the race outputs that
// travel between the menu stage, this tracker and the LED strip renderer.
interface race_position_tracker_if;
    logic       is_in_menu;
    logic       green_button;
    logic       red_button;
    logic       blue_button;
    logic       yellow_button;
    logic [5:0] green_position;
    logic [5:0] red_position;
    logic [5:0] blue_position;
    logic [5:0] yellow_position;
    logic [3:0] winner;
    logic       race_finished;
    logic       activity;

    modport master (
        output is_in_menu, green_button, red_button, blue_button, yellow_button,
        input  green_position, red_position, blue_position, yellow_position,
        input  winner, race_finished, activity
    );

    modport slave (
        input  is_in_menu, green_button, red_button, blue_button, yellow_button,
        output green_position, red_position, blue_position, yellow_position,
        output winner, race_finished, activity
    );
endinterface

// File: rtl/race_position_tracker.sv
// Turns debounced player presses into track positions once the menu phase ends,
// flags the winner(s) at the finish line and freezes until the menu returns.
module race_position_tracker #(
    parameter int MAX_POSITION       = 49,
    parameter int DEBOUNCE_CLK_COUNT = 500000
) (
    input logic                   clk,
    input logic                   reset,
    race_position_tracker_if.slave bus
);

    localparam int CNT_W = (DEBOUNCE_CLK_COUNT > 1) ? $clog2(DEBOUNCE_CLK_COUNT) : 1;
    localparam logic [CNT_W-1:0] LOCK_LOAD = CNT_W'(DEBOUNCE_CLK_COUNT - 1);
    localparam logic [5:0]       MAX_POS   = 6'(MAX_POSITION);

    typedef enum logic [1:0] {
        IDLE,
        RACING,
        FINISHED
    } state_t;

    // Player bit order everywhere is {yellow, blue, red, green}
    logic [3:0]       rawButtons;
    logic [3:0]       sync1_q, sync2_q, hist_q;
    logic [3:0]       press_q;
    logic [3:0]       rise, accept;
    logic [CNT_W-1:0] lock_q [4];
    logic [CNT_W-1:0] lock_d [4];

    state_t     state_q, state_d;
    logic [5:0] pos_q [4];
    logic [5:0] pos_d [4];
    logic [3:0] winner_q, winner_d;
    logic       finished_q, finished_d;
    logic       activity_q, activity_d;

    assign rawButtons = {bus.yellow_button, bus.blue_button, bus.red_button, bus.green_button};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
            hist_q  <= '0;
            press_q <= '0;
            for (int i = 0; i < 4; i++) begin
                lock_q[i] <= '0;
            end
        end else begin
            sync1_q <= rawButtons;
            sync2_q <= sync1_q;
            hist_q  <= sync2_q;
            press_q <= accept;
            for (int i = 0; i < 4; i++) begin
                lock_q[i] <= lock_d[i];
            end
        end
    end

    // Lockout runs regardless of race state so menu presses still arm it
    always_comb begin
        rise = sync2_q & ~hist_q;
        for (int i = 0; i < 4; i++) begin
            accept[i] = rise[i] && (lock_q[i] == '0);
            lock_d[i] = lock_q[i];
            if (accept[i]) begin
                lock_d[i] = LOCK_LOAD;
            end else if (lock_q[i] != '0) begin
                lock_d[i] = lock_q[i] - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            winner_q   <= '0;
            finished_q <= 1'b0;
            activity_q <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                pos_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            winner_q   <= winner_d;
            finished_q <= finished_d;
            activity_q <= activity_d;
            for (int i = 0; i < 4; i++) begin
                pos_q[i] <= pos_d[i];
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        winner_d   = winner_q;
        finished_d = finished_q;
        activity_d = 1'b0;
        for (int i = 0; i < 4; i++) begin
            pos_d[i] = pos_q[i];
        end

        case (state_q)
            IDLE: begin
                winner_d   = '0;
                finished_d = 1'b0;
                for (int i = 0; i < 4; i++) begin
                    pos_d[i] = '0;
                end
                if (!bus.is_in_menu) begin
                    state_d = RACING;
                end
            end
            RACING: begin
                for (int i = 0; i < 4; i++) begin
                    if (press_q[i] && (pos_q[i] < MAX_POS)) begin
                        pos_d[i]   = pos_q[i] + 6'd1;
                        activity_d = 1'b1;
                        if ((pos_q[i] + 6'd1) == MAX_POS) begin
                            winner_d[i] = 1'b1;
                        end
                    end
                end
                if (winner_d != '0) begin
                    state_d    = FINISHED;
                    finished_d = 1'b1;
                end
            end
            FINISHED: begin
                finished_d = 1'b1;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Menu always wins, even over a press landing in the same cycle
        if (bus.is_in_menu) begin
            state_d    = IDLE;
            winner_d   = '0;
            finished_d = 1'b0;
            activity_d = 1'b0;
            for (int i = 0; i < 4; i++) begin
                pos_d[i] = '0;
            end
        end
    end

    assign bus.green_position  = pos_q[0];
    assign bus.red_position    = pos_q[1];
    assign bus.blue_position   = pos_q[2];
    assign bus.yellow_position = pos_q[3];
    assign bus.winner          = winner_q;
    assign bus.race_finished   = finished_q;
    assign bus.activity        = activity_q;

endmodule

// File: tb/tb_race_position_tracker.sv
// Self-checking bench for race_position_tracker: directed scenarios plus a
// randomized run against an event-level model of presses, lockout and race rules.
module tb_race_position_tracker;

    localparam int MAX = 3;
    localparam int DEB = 4;

    logic       clk;
    logic       reset;
    logic       menu;
    logic [3:0] btn;
    int         assertCount = 0;
    int         failCount   = 0;

    race_position_tracker_if bus ();

    race_position_tracker #(
        .MAX_POSITION      (MAX),
        .DEBOUNCE_CLK_COUNT(DEB)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    assign bus.is_in_menu    = menu;
    assign bus.green_button  = btn[0];
    assign bus.red_button    = btn[1];
    assign bus.blue_button   = btn[2];
    assign bus.yellow_button = btn[3];

    logic [5:0] dutPos [4];
    assign dutPos[0] = bus.green_position;
    assign dutPos[1] = bus.red_position;
    assign dutPos[2] = bus.blue_position;
    assign dutPos[3] = bus.yellow_position;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model: button samples per edge, last accepted edge per player
    int         edgeIdx;
    int         lastAcc [4];
    logic [3:0] b1, b2, b3;
    logic [3:0] mPend;
    int         mPos [4];
    logic [3:0] mWinner;
    logic       mFin, mAct;
    int         mPhase;

    task automatic modelReset();
        edgeIdx = 0;
        b1 = '0; b2 = '0; b3 = '0;
        mPend = '0;
        mWinner = '0; mFin = 1'b0; mAct = 1'b0;
        mPhase = 0;
        for (int i = 0; i < 4; i++) begin
            lastAcc[i] = -1000000;
            mPos[i] = 0;
        end
    endtask

    task automatic modelEdge();
        logic [3:0] b0, acc;
        b0 = btn;
        edgeIdx++;
        for (int i = 0; i < 4; i++) begin
            acc[i] = b2[i] && !b3[i] && ((edgeIdx - lastAcc[i]) >= DEB);
            if (acc[i]) lastAcc[i] = edgeIdx;
        end
        mAct = 1'b0;
        if (menu || mPhase == 0) begin
            for (int i = 0; i < 4; i++) mPos[i] = 0;
            mWinner = '0;
            mFin = 1'b0;
            mPhase = menu ? 0 : 1;
        end else if (mPhase == 1) begin
            for (int i = 0; i < 4; i++) begin
                if (mPend[i] && mPos[i] < MAX) begin
                    mPos[i]++;
                    mAct = 1'b1;
                    if (mPos[i] == MAX) mWinner[i] = 1'b1;
                end
            end
            if (mWinner != '0) begin
                mPhase = 2;
                mFin = 1'b1;
            end
        end
        mPend = acc;
        b3 = b2; b2 = b1; b1 = b0;
    endtask

    task automatic stepCycle();
        @(posedge clk);
        modelEdge();
        @(negedge clk);
    endtask

    task automatic goRace();
        btn = '0;
        menu = 1'b1;
        repeat (2) stepCycle();
        menu = 1'b0;
        repeat (8) stepCycle();
    endtask

    task automatic test_reset();
        #1;
        for (int i = 0; i < 4; i++) begin
            assertCount++;
            if (dutPos[i] !== 6'd0) begin
                failCount++;
                $display("[TB] FAIL reset_pos%0d: got %0d expected 0", i, dutPos[i]);
            end
        end
        assertCount++;
        if (bus.winner !== 4'b0000 || bus.race_finished !== 1'b0 || bus.activity !== 1'b0) begin
            failCount++;
            $display("[TB] FAIL reset_flags: got winner=%b fin=%b act=%b expected 0000/0/0",
                     bus.winner, bus.race_finished, bus.activity);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        modelReset();
    endtask

    task automatic test_latency();
        logic [5:0] expPos;
        logic       expAct;
        goRace();
        btn[0] = 1'b1;
        for (int c = 1; c <= 6; c++) begin
            stepCycle();
            if (c == 1) btn[0] = 1'b0;
            expPos = (c >= 4) ? 6'd1 : 6'd0;
            expAct = (c == 4);
            assertCount++;
            if (bus.green_position !== expPos) begin
                failCount++;
                $display("[TB] FAIL latency_pos edge+%0d: got %0d expected %0d", c - 1, bus.green_position, expPos);
            end
            assertCount++;
            if (bus.activity !== expAct) begin
                failCount++;
                $display("[TB] FAIL latency_act edge+%0d: got %b expected %b", c - 1, bus.activity, expAct);
            end
        end
        assertCount++;
        if (bus.red_position !== 6'd0 || bus.blue_position !== 6'd0 || bus.yellow_position !== 6'd0) begin
            failCount++;
            $display("[TB] FAIL latency_others: got %0d/%0d/%0d expected 0/0/0",
                     bus.red_position, bus.blue_position, bus.yellow_position);
        end
    endtask

    task automatic test_debounce();
        int actCount;
        goRace();
        actCount = 0;
        btn[0] = 1'b1; stepCycle();
        btn[0] = 1'b0; stepCycle();
        btn[0] = 1'b1; stepCycle();
        btn[0] = 1'b0;
        repeat (10) begin
            stepCycle();
            if (bus.activity === 1'b1) actCount++;
        end
        assertCount++;
        if (bus.green_position !== 6'd1 || actCount != 1) begin
            failCount++;
            $display("[TB] FAIL debounce_bounce: got pos=%0d pulses=%0d expected pos=1 pulses=1",
                     bus.green_position, actCount);
        end
        btn[0] = 1'b1; stepCycle();
        btn[0] = 1'b0;
        repeat (6) stepCycle();
        assertCount++;
        if (bus.green_position !== 6'd2) begin
            failCount++;
            $display("[TB] FAIL debounce_second: got %0d expected 2", bus.green_position);
        end
        // Rise 3 edges after an accepted one is dropped, 4 edges after is taken
        goRace();
        btn[1] = 1'b1; stepCycle();
        btn[1] = 1'b0; repeat (2) stepCycle();
        btn[1] = 1'b1; stepCycle();
        btn[1] = 1'b0; repeat (8) stepCycle();
        assertCount++;
        if (bus.red_position !== 6'd1) begin
            failCount++;
            $display("[TB] FAIL lockout_gap3: got %0d expected 1", bus.red_position);
        end
        btn[1] = 1'b1; stepCycle();
        btn[1] = 1'b0; repeat (3) stepCycle();
        btn[1] = 1'b1; stepCycle();
        btn[1] = 1'b0; repeat (8) stepCycle();
        assertCount++;
        if (bus.red_position !== 6'd3) begin
            failCount++;
            $display("[TB] FAIL lockout_gap4: got %0d expected 3", bus.red_position);
        end
    endtask

    task automatic test_menu_gating();
        int bad;
        btn = '0;
        menu = 1'b1;
        bad = 0;
        for (int p = 0; p < 5; p++) begin
            btn = 4'hF;
            repeat (3) stepCycle();
            btn = 4'h0;
            repeat (3) begin
                stepCycle();
                if (bus.activity !== 1'b0 || bus.green_position !== 6'd0 || bus.red_position !== 6'd0 ||
                    bus.blue_position !== 6'd0 || bus.yellow_position !== 6'd0) bad++;
            end
        end
        assertCount++;
        if (bad != 0) begin
            failCount++;
            $display("[TB] FAIL menu_gating: got %0d non-zero cycles expected 0", bad);
        end
        menu = 1'b0;
        repeat (8) stepCycle();
        btn[2] = 1'b1; stepCycle();
        btn[2] = 1'b0; repeat (5) stepCycle();
        assertCount++;
        if (bus.blue_position !== 6'd1 || bus.green_position !== 6'd0) begin
            failCount++;
            $display("[TB] FAIL menu_release: got blue=%0d green=%0d expected 1/0",
                     bus.blue_position, bus.green_position);
        end
    endtask

    task automatic test_win_tie();
        goRace();
        repeat (2) begin
            btn = 4'b0110; stepCycle();
            btn = 4'b0000; repeat (7) stepCycle();
        end
        assertCount++;
        if (bus.red_position !== 6'd2 || bus.blue_position !== 6'd2 || bus.winner !== 4'b0000) begin
            failCount++;
            $display("[TB] FAIL tie_setup: got red=%0d blue=%0d winner=%b expected 2/2/0000",
                     bus.red_position, bus.blue_position, bus.winner);
        end
        btn = 4'b0110; stepCycle();
        btn = 4'b0000; repeat (2) stepCycle();
        assertCount++;
        if (bus.race_finished !== 1'b0) begin
            failCount++;
            $display("[TB] FAIL tie_early: got fin=%b expected 0", bus.race_finished);
        end
        stepCycle();
        assertCount++;
        if (bus.red_position !== 6'd3 || bus.blue_position !== 6'd3 || bus.winner !== 4'b0110 ||
            bus.race_finished !== 1'b1 || bus.activity !== 1'b1) begin
            failCount++;
            $display("[TB] FAIL tie_win: got red=%0d blue=%0d winner=%b fin=%b act=%b expected 3/3/0110/1/1",
                     bus.red_position, bus.blue_position, bus.winner, bus.race_finished, bus.activity);
        end
        repeat (3) begin
            btn = 4'hF; stepCycle();
            btn = 4'h0; repeat (6) stepCycle();
        end
        assertCount++;
        if (bus.green_position !== 6'd0 || bus.yellow_position !== 6'd0 || bus.red_position !== 6'd3 ||
            bus.winner !== 4'b0110 || bus.race_finished !== 1'b1 || bus.activity !== 1'b0) begin
            failCount++;
            $display("[TB] FAIL tie_frozen: got g=%0d y=%0d r=%0d winner=%b fin=%b expected 0/0/3/0110/1",
                     bus.green_position, bus.yellow_position, bus.red_position, bus.winner, bus.race_finished);
        end
    endtask

    task automatic test_return_menu();
        menu = 1'b1;
        stepCycle();
        assertCount++;
        if (bus.red_position !== 6'd0 || bus.blue_position !== 6'd0 || bus.winner !== 4'b0000 ||
            bus.race_finished !== 1'b0) begin
            failCount++;
            $display("[TB] FAIL menu_return: got r=%0d b=%0d winner=%b fin=%b expected 0/0/0000/0",
                     bus.red_position, bus.blue_position, bus.winner, bus.race_finished);
        end
        menu = 1'b0;
        repeat (6) stepCycle();
        btn[3] = 1'b1; stepCycle();
        btn[3] = 1'b0; repeat (5) stepCycle();
        assertCount++;
        if (bus.yellow_position !== 6'd1 || bus.race_finished !== 1'b0) begin
            failCount++;
            $display("[TB] FAIL menu_resume: got yellow=%0d fin=%b expected 1/0",
                     bus.yellow_position, bus.race_finished);
        end
    endtask

    task automatic test_random();
        int menuHold;
        menuHold = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            for (int i = 0; i < 4; i++) begin
                if ($urandom_range(0, 3) == 0) btn[i] = ~btn[i];
            end
            if (menuHold > 0) begin
                menu = 1'b1;
                menuHold--;
            end else begin
                menu = 1'b0;
                if ($urandom_range(0, 39) == 0) menuHold = $urandom_range(1, 3);
            end
            stepCycle();
            for (int i = 0; i < 4; i++) begin
                assertCount++;
                if (dutPos[i] !== 6'(mPos[i])) begin
                    failCount++;
                    $display("[TB] FAIL rand_pos%0d cycle %0d: got %0d expected %0d", i, cyc, dutPos[i], mPos[i]);
                end
            end
            assertCount++;
            if (bus.winner !== mWinner || bus.race_finished !== mFin || bus.activity !== mAct) begin
                failCount++;
                $display("[TB] FAIL rand_flags cycle %0d: got winner=%b fin=%b act=%b expected %b/%b/%b",
                         cyc, bus.winner, bus.race_finished, bus.activity, mWinner, mFin, mAct);
            end
        end
        btn = '0;
        menu = 1'b0;
    endtask

    task automatic test_reset_mid();
        goRace();
        btn[0] = 1'b1; stepCycle();
        btn[0] = 1'b0; repeat (5) stepCycle();
        #2;
        reset = 1'b0;
        #1;
        assertCount++;
        if (bus.green_position !== 6'd0 || bus.winner !== 4'b0000 || bus.race_finished !== 1'b0 ||
            bus.activity !== 1'b0) begin
            failCount++;
            $display("[TB] FAIL reset_mid: got green=%0d winner=%b fin=%b act=%b expected 0/0000/0/0",
                     bus.green_position, bus.winner, bus.race_finished, bus.activity);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        modelReset();
        btn[0] = 1'b1;
        for (int c = 1; c <= 6; c++) begin
            stepCycle();
            if (c == 1) btn[0] = 1'b0;
            assertCount++;
            if (bus.green_position !== 6'(mPos[0]) || bus.activity !== mAct) begin
                failCount++;
                $display("[TB] FAIL reset_release edge %0d: got pos=%0d act=%b expected %0d/%b",
                         c, bus.green_position, bus.activity, mPos[0], mAct);
            end
        end
        assertCount++;
        if (bus.green_position !== 6'd1) begin
            failCount++;
            $display("[TB] FAIL reset_release_final: got %0d expected 1", bus.green_position);
        end
    endtask

    initial begin
        reset = 1'b1;
        menu  = 1'b1;
        btn   = '0;
        modelReset();
        #2;
        reset = 1'b0;
        test_reset();
        test_latency();
        test_debounce();
        test_menu_gating();
        test_win_tie();
        test_return_menu();
        test_random();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
